conversor_binario_bcd: RTL and testbench
========================================

// Module: conversor_binario_bcd
// PURPOSE
//  Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
//  Sits directly upstream of the 6-digit 7-segment decoder: takes an unsigned
//  binary value and produces the packed 24-bit BCD word that drives it.
//  The start/done handshake lets game/score logic request a conversion only
//  when the displayed value changes.
// PARAMETERS
//  N_BITS     20  width of the binary input; also the number of shift cycles
//  N_DIGITOS  6   number of BCD digits produced; BCD width = 4*N_DIGITOS
// PORTS
//  clk      in   1               system clock; all state changes on rising edge
//  rst_n    in   1               asynchronous, active-low reset
//  inicio   in   1               start request, sampled only in OCIOSO
//  binario  in   N_BITS          unsigned value, captured on the accepting edge
//  BCD      out  4*N_DIGITOS     packed BCD, digit0 in [3:0]; registered
//  ocupado  out  1               high from the accept edge until the result edge
//  pronto   out  1               one-cycle pulse: BCD/estouro just updated
//  estouro  out  1               last result saturated; registered with BCD
// BEHAVIOUR
//  Reset (asynchronous, rst_n=0): state=OCIOSO; BCD=0; ocupado=0; pronto=0;
//   estouro=0; shift register and counter cleared.
//  FSM states: OCIOSO -> DESLOCA -> FIM -> OCIOSO.
//  OCIOSO: if inicio=1 at edge E0, then:
//   - capture binario into the shift register; clear the BCD accumulator;
//   - set the bit counter to 0, ocupado to 1, and go to DESLOCA.
//   - If inicio=0, hold; BCD and estouro keep their last values.
//  DESLOCA (edges E1..E_N_BITS), per edge:
//   - each 4-bit accumulator digit >=5 gets +3 first;
//   - then shift {accumulator, binary} left 1, binary MSB first;
//   - increment the counter. At the edge where counter = N_BITS-1,
//     go to FIM.
//  FIM (edge E_N_BITS+1):
//   - load the BCD output register; set pronto=1 and ocupado=0;
//   - return to OCIOSO.
//   - For the defaults, BCD is valid after E21: 21 cycles from the accept edge.
//  pronto is high for exactly the one cycle after E_N_BITS+1, then 0 again.
//  Overflow: binario > 10^N_DIGITOS-1 (e.g. >999999).
//   - Compare on the captured value.
//   - On overflow, FIM loads BCD with all digits 9 and sets estouro=1.
//   - Otherwise estouro=0.
//   - Internal accumulator is 4*N_DIGITOS+4 bits so no intermediate bit is lost.
//  inicio while ocupado=1 is ignored (no queuing). A new inicio is accepted
//   in the cycle pronto=1, because the state is already OCIOSO.
//  binario changes after the accept edge do not affect the conversion in flight.
//  BCD never shows partial results; it changes only at the FIM edge or on reset.
//  Reset mid-conversion aborts immediately: all outputs return to reset values.
//   No pronto pulse follows.
// TESTING
//  1 Reset, then inicio for 1 cycle with binario=0:
//    BCD=24'h000000, estouro=0, pronto pulse after exactly 21 cycles.
//  2 binario=123456, then 999999:
//    BCD=24'h123456, then 24'h999999; estouro=0 both times;
//    ocupado high exactly 21 cycles each.
//  3 binario=1000000, then 1048575:
//    BCD=24'h999999, estouro=1 both times;
//    then binario=42 gives BCD=24'h000042, estouro=0.
//  4 Pulse inicio at cycle 5 of a conversion of 777, with binario changed
//    to 555 meanwhile:
//    ignored; a single result BCD=24'h000777 with one pronto pulse;
//    re-issue inicio in the pronto cycle and get 24'h000555 21 cycles later.
//  5 Hold inicio high continuously with binario=314159:
//    back-to-back conversions, pronto every 22 cycles, BCD stable at 24'h314159.
//  6 Assert rst_n=0 asynchronously (between edges) at cycle 10 of a conversion:
//    BCD=0, ocupado=0, pronto=0 immediately;
//    no pronto after release; next conversion of 65 gives 24'h000065.

Source files
------------

// File: rtl/conversor_binario_bcd.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one input bit per clock).
// Feeds the 6-digit 7-segment decoder; start/done handshake lets the score
// logic request a conversion only when the displayed value changes.
module conversor_binario_bcd #(
    parameter int N_BITS    = 20,
    parameter int N_DIGITOS = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   inicio,
    input  logic [N_BITS-1:0]      binario,
    output logic [4*N_DIGITOS-1:0] BCD,
    output logic                   ocupado,
    output logic                   pronto,
    output logic                   estouro
);

    localparam int BCD_W = 4 * N_DIGITOS;
    // One spare digit so the top shifted-out bit of an oversized value is kept.
    localparam int ACC_W = BCD_W + 4;
    localparam int CNT_W = $clog2(N_BITS + 1);

    localparam logic [1:0] OCIOSO  = 2'd0;
    localparam logic [1:0] DESLOCA = 2'd1;
    localparam logic [1:0] FIM     = 2'd2;

    // Largest value representable with N_DIGITOS decimal digits.
    function automatic logic [63:0] limite_decimal(input int digitos);
        logic [63:0] v;
        v = 64'd1;
        for (int i = 0; i < digitos; i++) begin
            v = v * 64'd10;
        end
        return v - 64'd1;
    endfunction

    localparam logic [63:0] LIMITE = limite_decimal(N_DIGITOS);
    localparam logic [BCD_W-1:0] TODOS_NOVE = {N_DIGITOS{4'h9}};

    // Add 3 to every digit that is 5 or more, ahead of the next left shift.
    function automatic logic [ACC_W-1:0] ajusta_digitos(input logic [ACC_W-1:0] a);
        logic [ACC_W-1:0] r;
        r = a;
        for (int i = 0; i < ACC_W / 4; i++) begin
            if (r[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = r[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    logic [1:0]        r_estado;
    logic [CNT_W-1:0]  r_cont;
    logic [N_BITS-1:0] r_bin;
    logic [ACC_W-1:0]  r_acc;
    logic              r_estouro_cap;

    logic [ACC_W-1:0]  w_acc_aj;
    logic              w_estouro;

    assign w_acc_aj  = ajusta_digitos(r_acc);
    assign w_estouro = ({{(64-N_BITS){1'b0}}, binario} > LIMITE);

    // Control FSM plus shift datapath; BCD output only moves at the FIM edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado      <= OCIOSO;
            r_cont        <= '0;
            r_bin         <= '0;
            r_acc         <= '0;
            r_estouro_cap <= 1'b0;
            BCD           <= '0;
            ocupado       <= 1'b0;
            pronto        <= 1'b0;
            estouro       <= 1'b0;
        end else begin
            pronto <= 1'b0;
            case (r_estado)
                OCIOSO: begin
                    if (inicio) begin
                        r_bin         <= binario;
                        r_acc         <= '0;
                        r_cont        <= '0;
                        r_estouro_cap <= w_estouro;
                        ocupado       <= 1'b1;
                        r_estado      <= DESLOCA;
                    end
                end
                DESLOCA: begin
                    r_acc  <= {w_acc_aj[ACC_W-2:0], r_bin[N_BITS-1]};
                    r_bin  <= {r_bin[N_BITS-2:0], 1'b0};
                    r_cont <= r_cont + 1'b1;
                    if (r_cont == CNT_W'(N_BITS - 1)) begin
                        r_estado <= FIM;
                    end
                end
                FIM: begin
                    BCD      <= r_estouro_cap ? TODOS_NOVE : r_acc[BCD_W-1:0];
                    estouro  <= r_estouro_cap;
                    pronto   <= 1'b1;
                    ocupado  <= 1'b0;
                    r_estado <= OCIOSO;
                end
                default: begin
                    r_estado <= OCIOSO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conversor_binario_bcd.sv
// Scoreboard bench for conversor_binario_bcd: a cycle-level handshake model
// pushes decimal-arithmetic expectations; a monitor pops them on pronto.
module tb_conversor_binario_bcd;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        inicio = 1'b0;
    logic [19:0] binario = '0;
    logic [23:0] BCD;
    logic        ocupado;
    logic        pronto;
    logic        estouro;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [23:0] bcd;
        logic        est;
    } res_t;

    res_t sb[$];
    res_t pendente = '0;
    res_t disp = '0;
    int   cyc = 0;
    int   last_acc = -100;

    conversor_binario_bcd #(.N_BITS(20), .N_DIGITOS(6)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .inicio  (inicio),
        .binario (binario),
        .BCD     (BCD),
        .ocupado (ocupado),
        .pronto  (pronto),
        .estouro (estouro)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nome, act, exp, $time);
        end
    endtask

    // Decimal reference: digit by digit with / and %, saturating above 999999.
    function automatic res_t ref_model(input int unsigned v);
        res_t r;
        r = '0;
        if (v > 999999) begin
            r.bcd = 24'h999999;
            r.est = 1'b1;
        end else begin
            for (int i = 0; i < 6; i++) begin
                r.bcd[4*i +: 4] = 4'(v % 10);
                v = v / 10;
            end
        end
        return r;
    endfunction

    // Handshake model: accept when idle, result 21 edges later, idle again at +22.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc      = 0;
            last_acc = -100;
            sb.delete();
            disp     = '0;
        end else begin
            cyc = cyc + 1;
            if (cyc == last_acc + 21) disp = pendente;
            if (cyc >= last_acc + 22 && inicio === 1'b1) begin
                last_acc = cyc;
                pendente = ref_model(int'(binario));
                sb.push_back(pendente);
            end
        end
    end

    // Monitor: timing of ocupado/pronto, stable outputs, scoreboard pop on pronto.
    always @(negedge clk) begin
        if (rst_n) begin
            res_t e;
            chk("ocupado", 32'(ocupado), 32'(cyc >= last_acc && cyc <= last_acc + 20));
            chk("pronto", 32'(pronto), 32'(cyc == last_acc + 21));
            chk("BCD_estavel", 32'(BCD), 32'(disp.bcd));
            chk("estouro_estavel", 32'(estouro), 32'(disp.est));
            if (pronto === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("pronto_sem_pedido", 32'(1), 32'(0));
                end else begin
                    e = sb.pop_front();
                    chk("sb_BCD", 32'(BCD), 32'(e.bcd));
                    chk("sb_estouro", 32'(estouro), 32'(e.est));
                end
            end
        end
    end

    task automatic start(input logic [19:0] v);
        @(negedge clk);
        binario = v;
        inicio  = 1'b1;
        @(negedge clk);
        inicio  = 1'b0;
    endtask

    task automatic wait_pronto();
        int k;
        k = 0;
        while (pronto !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (pronto !== 1'b1) chk("timeout_pronto", 32'(0), 32'(1));
    endtask

    task automatic convert(input logic [19:0] v);
        start(v);
        wait_pronto();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_BCD", 32'(BCD), 32'(0));
        chk("reset_ocupado", 32'(ocupado), 32'(0));
        chk("reset_pronto", 32'(pronto), 32'(0));
        chk("reset_estouro", 32'(estouro), 32'(0));
        rst_n = 1'b1;

        // Zero, mid-range, upper limit, overflow, recovery.
        convert(20'd0);
        convert(20'd123456);
        convert(20'd999999);
        convert(20'd1000000);
        convert(20'd1048575);
        convert(20'd42);

        // inicio while busy is ignored; binario change after accept ignored.
        start(20'd777);
        repeat (3) @(negedge clk);
        binario = 20'd555;
        inicio  = 1'b1;
        @(negedge clk);
        inicio  = 1'b0;
        wait_pronto();
        inicio = 1'b1;
        @(negedge clk);
        inicio = 1'b0;
        wait_pronto();
        repeat (2) @(negedge clk);

        // Held inicio: back-to-back conversions every 22 cycles.
        @(negedge clk);
        binario = 20'd314159;
        inicio  = 1'b1;
        repeat (70) @(negedge clk);
        inicio = 1'b0;
        repeat (30) @(negedge clk);

        // Asynchronous reset mid-conversion.
        start(20'd999);
        repeat (9) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_BCD", 32'(BCD), 32'(0));
        chk("rst_async_ocupado", 32'(ocupado), 32'(0));
        chk("rst_async_pronto", 32'(pronto), 32'(0));
        chk("rst_async_estouro", 32'(estouro), 32'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        convert(20'd65);

        // Random traffic: sporadic inicio, binario changing freely.
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            inicio = ($urandom_range(0, 5) == 0);
            case ($urandom_range(0, 7))
                0: binario = 20'd999999;
                1: binario = 20'd1000000;
                2: binario = 20'd0;
                3: binario = 20'hFFFFF;
                default: binario = 20'($urandom_range(0, 1048575));
            endcase
        end
        inicio = 1'b0;
        repeat (30) @(negedge clk);

        chk("fila_vazia", 32'(sb.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
